read_reorder_buffer: RTL
========================

// Module: read_reorder_buffer
// PURPOSE
//  In-order read response buffer (ROB) for the DRAM cache read path.
//  The AR front-end allocates one transaction ID (TID) per accepted AXI read, in order.
//  The hit path and the read-miss handler fill entries out of order as {tid,data}.
//  Completed entries are returned on the AXI R channel in allocation order.
// PARAMETERS
//  DATA_WIDTH  `AXI_DATA_WIDTH  read data width
//  TID_WIDTH   `TID_WIDTH       TID width; DEPTH = 1<<TID_WIDTH entries (localparam)
//  ID_WIDTH    `AXI_ID_WIDTH    AXI ID width, stored per entry
// PORTS
//  clk           in   1                     clock
//  rst_n         in   1                     synchronous reset, active-low
//  alloc_valid_i in   1                     AR front-end requests a TID
//  alloc_ready_o out  1                     a free entry exists (count != DEPTH)
//  alloc_id_i    in   ID_WIDTH              AXI ARID stored in the allocated entry
//  alloc_tid_o   out  TID_WIDTH             TID granted (current alloc pointer)
//  hit_wen_i     in   1                     hit-path fill strobe (priority port)
//  hit_wdata_i   in   DATA_WIDTH+TID_WIDTH  {tid,data}; tid in MSBs
//  write_en_i    in   1                     miss-handler fill strobe
//  wdata_i       in   DATA_WIDTH+TID_WIDTH  {tid,data}; tid in MSBs
//  full_o        out  1                     miss fill port blocked (= hit_wen_i, combinational)
//  rvalid_o      out  1                     AXI R valid
//  rready_i      in   1                     AXI R ready
//  rdata_o       out  DATA_WIDTH            AXI R data
//  rid_o         out  ID_WIDTH              AXI R ID
//  rresp_o       out  2                     always 2'b00 (OKAY)
//  rlast_o       out  1                     always 1 (single beat)
//  err_o         out  1                     sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every entry valid=0 and done=0; wr_ptr=rd_ptr=0; count=0;
//   rvalid_o=0, rdata_o=0, rid_o=0, err_o=0.
//  Per-entry state: valid (allocated), done (filled), data, id.
//  Allocation:
//   - Fires when alloc_valid_i & alloc_ready_o.
//   - Sets entry[wr_ptr].valid and stores id; wr_ptr++ (wraps mod DEPTH); count++.
//   - alloc_ready_o is taken from registers only, with no same-cycle bypass of a freed entry.
//  Fill:
//   - A hit fill has priority. The miss fill is accepted only when write_en_i & !full_o.
//   - A miss fill presented while full_o=1 is ignored; the miss handler holds and retries.
//   - Fill at edge N writes data and sets done, visible at N+1.
//  Retire:
//   - Output stage loads when (!rvalid_o | rready_i) & entry[rd_ptr].done.
//   - On load: rdata_o/rid_o <= entry data/id; rvalid_o <= 1; valid and done cleared; rd_ptr++; count--.
//   - Otherwise, a rvalid_o & rready_i handshake clears rvalid_o.
//   - Back-to-back throughput is 1 response/cycle while rready_i stays 1.
//   - Minimum fill-to-rvalid latency is 2 cycles.
//  rvalid_o is held until handshaken; rdata_o and rid_o are stable while rvalid_o & !rready_i.
//  Simultaneous events:
//   - Alloc and retire in one cycle: count unchanged.
//   - Fill to rd_ptr in the same cycle as a retire check: retire waits for the done flag (next cycle).
//   - Two fills with the same TID in one cycle: the hit fill wins and the miss fill is blocked by full_o.
//  Wrap-around:
//   - Pointers are TID_WIDTH bits; count is TID_WIDTH+1 bits.
//   - full  <=> count==DEPTH; empty <=> count==0.
//  Reset mid-operation discards all entries and any pending response with no R beat emitted.
// CONFIGURATION
//  Macro ROB_ERR_CHECK_EN.
//  Defined:
//   - A fill whose target entry has valid=0 or done=1 is dropped and sets err_o=1, sticky until reset.
//   - Dropped fills have no effect on data or done.
//  Not defined:
//   - Fills write unconditionally.
//   - err_o is tied to 0.
// TESTING
//  1. Allocate 3 TIDs (ids 5,6,7); miss-fill tid2, tid0, tid1 with data A2, A0, A1.
//     Expect R beats id5/A0, id6/A1, id7/A2, in that order, rlast=1.
//  2. Allocate DEPTH TIDs. Expect alloc_ready_o=0.
//     Fill+retire one entry. Expect alloc_ready_o=1 the cycle after the handshake; the next TID is 0 (wrap).
//  3. Assert hit_wen_i (tid0) and write_en_i (tid1) together. Expect full_o=1 and only tid0 filled.
//     Miss retry next cycle fills tid1.
//  4. Drive rready_i=0 for 4 cycles with rvalid_o=1. Expect rdata_o/rid_o stable.
//     Release rready_i. Expect 1 beat/cycle until drained.
//  5. Apply rst_n=0 with 3 filled, unretired entries. Expect rvalid_o=0, alloc_tid_o=0, alloc_ready_o=1 next cycle.
//  6. With ROB_ERR_CHECK_EN, fill an unallocated tid. Expect err_o=1 sticky and no R beat.
//     Without the macro, expect err_o=0.

Source files
------------

// File: rtl/read_reorder_buffer_if.sv
// Bundles the alloc, fill, AXI R and error signals of the read reorder buffer.
// The master modport belongs to the surrounding read path; the slave modport belongs to the buffer.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 3
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

interface read_reorder_buffer_if #(
   parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
   parameter int TID_WIDTH  = `TID_WIDTH,
   parameter int ID_WIDTH   = `AXI_ID_WIDTH
);
   logic                            alloc_valid_i;
   logic                            alloc_ready_o;
   logic [ID_WIDTH-1:0]             alloc_id_i;
   logic [TID_WIDTH-1:0]            alloc_tid_o;
   logic                            hit_wen_i;
   logic [DATA_WIDTH+TID_WIDTH-1:0] hit_wdata_i;
   logic                            write_en_i;
   logic [DATA_WIDTH+TID_WIDTH-1:0] wdata_i;
   logic                            full_o;
   logic                            rvalid_o;
   logic                            rready_i;
   logic [DATA_WIDTH-1:0]           rdata_o;
   logic [ID_WIDTH-1:0]             rid_o;
   logic [1:0]                      rresp_o;
   logic                            rlast_o;
   logic                            err_o;

   modport master (
      output alloc_valid_i, alloc_id_i, hit_wen_i, hit_wdata_i, write_en_i, wdata_i, rready_i,
      input  alloc_ready_o, alloc_tid_o, full_o, rvalid_o, rdata_o, rid_o, rresp_o, rlast_o, err_o
   );

   modport slave (
      input  alloc_valid_i, alloc_id_i, hit_wen_i, hit_wdata_i, write_en_i, wdata_i, rready_i,
      output alloc_ready_o, alloc_tid_o, full_o, rvalid_o, rdata_o, rid_o, rresp_o, rlast_o, err_o
   );
endinterface

// File: rtl/read_reorder_buffer.sv
// In-order read response buffer: TIDs are allocated in order, filled out of order, returned on AXI R in order.
// Define ROB_ERR_CHECK_EN to drop fills to unallocated or already-filled entries and flag them on err_o.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 3
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module read_reorder_buffer #(
   parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
   parameter int TID_WIDTH  = `TID_WIDTH,
   parameter int ID_WIDTH   = `AXI_ID_WIDTH
) (
   input logic                  clk,
   input logic                  rst_n,
   read_reorder_buffer_if.slave bus
);
   localparam int DEPTH  = 1 << TID_WIDTH;
   localparam int WORD_W = DATA_WIDTH + TID_WIDTH;

   typedef logic [TID_WIDTH-1:0]  tid_t;
   typedef logic [TID_WIDTH:0]    cnt_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ID_WIDTH-1:0]   id_t;

   localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

   tid_t             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   cnt_t             count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
   data_t            data_q [DEPTH];
   data_t            data_d [DEPTH];
   id_t              id_q [DEPTH];
   id_t              id_d [DEPTH];
   logic             rvalid_q, rvalid_d;
   data_t            rdata_q, rdata_d;
   id_t              rid_q, rid_d;
   logic             err_q, err_d;

   logic             alloc_fire, retire_fire, fill_en, fill_ok;
   logic [WORD_W-1:0] fill_word;
   tid_t             fill_tid;

   // The hit path owns the fill port whenever it strobes, so the miss handler sees a busy port.
   assign bus.full_o        = bus.hit_wen_i;
   assign bus.alloc_ready_o = (count_q != DEPTH_CNT);
   assign bus.alloc_tid_o   = wr_ptr_q;
   assign bus.rvalid_o      = rvalid_q;
   assign bus.rdata_o       = rdata_q;
   assign bus.rid_o         = rid_q;
   assign bus.rresp_o       = 2'b00;
   assign bus.rlast_o       = 1'b1;
   assign bus.err_o         = err_q;

   always_comb begin
      // NOTE: every signal gets a default before any condition so no latch can be inferred.
      alloc_fire  = bus.alloc_valid_i & bus.alloc_ready_o;
      retire_fire = (!rvalid_q | bus.rready_i) & done_q[rd_ptr_q];
      fill_en     = bus.hit_wen_i | bus.write_en_i;
      fill_word   = bus.hit_wen_i ? bus.hit_wdata_i : bus.wdata_i;
      fill_tid    = fill_word[WORD_W-1 -: TID_WIDTH];
`ifdef ROB_ERR_CHECK_EN
      fill_ok = fill_en & valid_q[fill_tid] & !done_q[fill_tid];
      err_d   = err_q | (fill_en & !fill_ok);
`else
      fill_ok = fill_en;
      err_d   = 1'b0;
`endif
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      valid_d  = valid_q;
      done_d   = done_q;
      data_d   = data_q;
      id_d     = id_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rid_d    = rid_q;
      count_d  = count_q + cnt_t'(alloc_fire) - cnt_t'(retire_fire);

      if (retire_fire) begin
         rvalid_d           = 1'b1;
         rdata_d            = data_q[rd_ptr_q];
         rid_d              = id_q[rd_ptr_q];
         valid_d[rd_ptr_q]  = 1'b0;
         done_d[rd_ptr_q]   = 1'b0;
         rd_ptr_d           = rd_ptr_q + tid_t'(1);
      end else if (rvalid_q && bus.rready_i) begin
         rvalid_d = 1'b0;
      end

      if (alloc_fire) begin
         valid_d[wr_ptr_q] = 1'b1;
         id_d[wr_ptr_q]    = bus.alloc_id_i;
         wr_ptr_d          = wr_ptr_q + tid_t'(1);
      end

      if (fill_ok) begin
         data_d[fill_tid] = fill_word[DATA_WIDTH-1:0];
         done_d[fill_tid] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         done_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rid_q    <= rid_d;
         err_q    <= err_d;
      end
   end

   // NOTE: payload storage has no reset; an entry is only read after valid/done say it was written.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      id_q   <= id_d;
   end
endmodule
